// File: rtl/risc_mem_pkg.sv
// Shared types for the MEM stage of the 16-bit RISC core: op encodings,
// datapath widths, drain FSM states and an address range helper.
package risc_mem_pkg;

    localparam int DATA_W = 16;
    localparam int RD_W   = 3;

    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        DR_IDLE  = 2'b00,
        DR_SETUP = 2'b01,
        DR_WRITE = 2'b10
    } drain_state_e;

    // True when a word address falls inside the implemented memory.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                           input int unsigned       words);
        return {16'b0, addr} < words;
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Store buffer FIFO: queued (addr, data) pairs with head/tail/count
// bookkeeping and a youngest-entry address lookup for store-to-load forwarding.
module store_buffer
    import risc_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    input  logic [DATA_W-1:0]              lookup_addr,
    output logic [DATA_W-1:0]              head_addr,
    output logic [DATA_W-1:0]              head_data,
    output logic [DATA_W-1:0]              next_addr,
    output logic [DATA_W-1:0]              next_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           full,
    output logic                           empty,
    output logic                           hit,
    output logic [DATA_W-1:0]              hit_data,
    output logic                           any_match
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  next_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [DEPTH-1:0]  match_vec;

    // Entry storage: only the tail slot is written on a push.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_d[i] = addr_q[i];
            data_d[i] = data_q[i];
        end
        if (push) begin
            addr_d[tail_q] = push_addr;
            data_d[tail_q] = push_data;
        end
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at PTR_W bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Per-slot match: slot holds a live entry (its age offset is below count)
    // and its address equals the lookup address.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] offset;
            assign offset        = PTR_W'(gi) - head_q;
            assign match_vec[gi] = ({1'b0, offset} < count_q) && (addr_q[gi] == lookup_addr);
        end
    endgenerate

    // Youngest match: scan oldest to youngest so the last hit wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (match_vec[scan_idx]) begin
                hit      = 1'b1;
                hit_data = data_q[scan_idx];
            end
        end
    end

    assign next_idx  = head_q + PTR_W'(1);
    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign next_addr = addr_q[next_idx];
    assign next_data = data_q[next_idx];
    assign any_match = |match_vec;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: EX handshake, registered WB outputs, store buffer and a
// two-phase (SETUP, WRITE) drain FSM toward a level-sensitive data memory.
// Optional feature macro STORE_FWD_EN: when defined, loads forward from the
// youngest matching queued store; otherwise a matching load stalls until the
// store has drained to memory.
module mem_access_unit
    import risc_mem_pkg::*;
#(
    parameter int SB_DEPTH  = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_op,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [RD_W-1:0]   ex_rd,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              addr_err,
    output logic [DATA_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    output logic [DATA_W-1:0] mem_addrb,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic              is_load, is_store, in_range;
    logic              accept, push, pop, stall_hazard;
    logic [DATA_W-1:0] head_addr, head_data, next_addr, next_data;
    logic [CNT_W-1:0]  count;
    logic              full, empty, hit, any_match;
    logic [DATA_W-1:0] hit_data;

    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              addr_err_q, addr_err_d;

    drain_state_e      state_q, state_d;
    logic [DATA_W-1:0] addra_q, addra_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wea_q, wea_d;

    assign is_load  = (ex_op == OP_LOAD);
    assign is_store = (ex_op == OP_STORE);
    assign in_range = addr_in_range(ex_addr, MEM_WORDS);

`ifdef STORE_FWD_EN
    // Every live match is forwardable, so this term never stalls.
    assign stall_hazard = any_match & ~hit;
`else
    assign stall_hazard = any_match;
`endif

    assign ex_ready  = !(is_store && full) && !(is_load && stall_hazard);
    assign accept    = ex_valid && ex_ready;
    assign push      = accept && is_store && in_range;
    assign mem_addrb = ex_addr;

    store_buffer #(
        .DEPTH (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (ex_addr),
        .push_data   (ex_wdata),
        .pop         (pop),
        .lookup_addr (ex_addr),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .next_addr   (next_addr),
        .next_data   (next_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .hit         (hit),
        .hit_data    (hit_data),
        .any_match   (any_match)
    );

    // WB result for the op accepted this cycle; stores report data 0.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = '0;
        wb_data_d  = '0;
        addr_err_d = 1'b0;
        if (accept) begin
            wb_valid_d = 1'b1;
            wb_we_d    = !is_store;
            wb_rd_d    = ex_rd;
            addr_err_d = (is_load || is_store) && !in_range;
            if (is_load) begin
                if (in_range) wb_data_d = hit ? hit_data : mem_dout;
            end else if (!is_store) begin
                wb_data_d = ex_alu;
            end
        end
    end

    // WB register toward the writeback stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Drain FSM: address/data are loaded while enable is low, enable is raised
    // for one cycle, and the head is popped on the edge that drops enable.
    always_comb begin
        state_d = state_q;
        addra_d = addra_q;
        din_d   = din_q;
        wea_d   = wea_q;
        pop     = 1'b0;
        case (state_q)
            DR_IDLE: begin
                if (!empty) begin
                    state_d = DR_SETUP;
                    addra_d = head_addr;
                    din_d   = head_data;
                    wea_d   = 1'b0;
                end
            end
            DR_SETUP: begin
                state_d = DR_WRITE;
                wea_d   = 1'b1;
            end
            DR_WRITE: begin
                pop   = 1'b1;
                wea_d = 1'b0;
                if (count > CNT_W'(1)) begin
                    state_d = DR_SETUP;
                    addra_d = next_addr;
                    din_d   = next_data;
                end else begin
                    state_d = DR_IDLE;
                end
            end
            default: begin
                state_d = DR_IDLE;
                wea_d   = 1'b0;
            end
        endcase
    end

    // Drain FSM state and memory write-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DR_IDLE;
            addra_q <= '0;
            din_q   <= '0;
            wea_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addra_q <= addra_d;
            din_q   <= din_d;
            wea_q   <= wea_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign addr_err  = addr_err_q;
    assign mem_addra = addra_q;
    assign mem_din   = din_q;
    assign mem_wea   = wea_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// traffic checked against a queue-and-array reference model and a 64-word memory.
module tb_mem_access_unit;

    localparam int SB_DEPTH  = 4;
    localparam int MEM_WORDS = 64;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_op;
    logic [15:0] ex_addr, ex_wdata, ex_alu;
    logic [2:0]  ex_rd;
    logic        wb_valid, wb_we, addr_err;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] mem_addra, mem_din, mem_addrb, mem_dout;
    logic        mem_wea;

    logic [15:0] mem [MEM_WORDS];

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;
    ent_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int gap   = 0;
    logic        prev_wea   = 1'b0;
    logic [15:0] prev_addra = '0;
    logic [15:0] prev_din   = '0;
    logic        last_acc, last_valid, last_we, last_err;
    logic [2:0]  last_rd;
    logic [15:0] last_data;

    always #5 clk = ~clk;

    assign mem_dout = (mem_addrb < 16'(MEM_WORDS)) ? mem[mem_addrb[5:0]] : 16'h0000;

    mem_access_unit #(
        .SB_DEPTH  (SB_DEPTH),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_alu    (ex_alu),
        .ex_rd     (ex_rd),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .addr_err  (addr_err),
        .mem_addra (mem_addra),
        .mem_din   (mem_din),
        .mem_wea   (mem_wea),
        .mem_addrb (mem_addrb),
        .mem_dout  (mem_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of traffic: predict from the model, check, then update the model.
    task automatic cycle();
        logic        is_ld, is_st, inr, hitq, exp_rdy, acc, exp_we, exp_err, wr;
        logic [15:0] fdata, exp_data, wa, wd;
        @(negedge clk);
        is_ld = (ex_op == 2'b01);
        is_st = (ex_op == 2'b10);
        inr   = (ex_addr < 16'(MEM_WORDS));
        hitq  = 1'b0;
        fdata = '0;
        foreach (sbq[i]) begin
            if (sbq[i].a == ex_addr) begin
                hitq  = 1'b1;
                fdata = sbq[i].d;
            end
        end
        exp_rdy = !(is_st && sbq.size() == SB_DEPTH) && !(is_ld && !FWD && hitq);
        chk("ex_ready", 32'(ex_ready), 32'(exp_rdy));
        acc     = ex_valid && exp_rdy;
        exp_we  = !is_st;
        exp_err = (is_ld || is_st) && !inr;
        if (is_st)      exp_data = 16'h0000;
        else if (is_ld) exp_data = !inr ? 16'h0000 : (hitq ? fdata : mem[ex_addr[5:0]]);
        else            exp_data = ex_alu;

        wr = mem_wea;
        wa = mem_addra;
        wd = mem_din;
        if (wr) begin
            chk("wea_single_cycle", 32'(prev_wea), 32'd0);
            chk("addra_stable", 32'(wa), 32'(prev_addra));
            chk("din_stable", 32'(wd), 32'(prev_din));
            if (sbq.size() == 0) begin
                chk("write_with_empty_model", 32'd1, 32'd0);
            end else begin
                chk("drain_addr_order", 32'(wa), 32'(sbq[0].a));
                chk("drain_data_order", 32'(wd), 32'(sbq[0].d));
            end
        end
        prev_wea   = wr;
        prev_addra = wa;
        prev_din   = wd;

        @(posedge clk);
        #1;
        if (wr) begin
            if (wa < 16'(MEM_WORDS)) mem[wa[5:0]] = wd;
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
        if (acc && is_st && inr) sbq.push_back('{a: ex_addr, d: ex_wdata});
        if (sbq.size() > 0 && !wr) gap++;
        else gap = 0;
        if (sbq.size() > 0) chk("drain_progress", 32'(gap <= 4), 32'd1);

        chk("wb_valid", 32'(wb_valid), 32'(acc));
        chk("addr_err", 32'(addr_err), 32'(acc && exp_err));
        if (acc) begin
            chk("wb_we", 32'(wb_we), 32'(exp_we));
            chk("wb_rd", 32'(wb_rd), 32'(ex_rd));
            chk("wb_data", 32'(wb_data), 32'(exp_data));
        end
        last_acc   = acc;
        last_valid = wb_valid;
        last_we    = wb_we;
        last_err   = addr_err;
        last_rd    = wb_rd;
        last_data  = wb_data;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] alu, input logic [2:0] rd, output int stalls);
        stalls   = 0;
        ex_valid = 1'b1;
        ex_op    = op;
        ex_addr  = addr;
        ex_wdata = wd;
        ex_alu   = alu;
        ex_rd    = rd;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (last_acc) break;
            stalls++;
        end
        if (!last_acc) chk("issue_timeout", 32'd1, 32'd0);
        $display("op=%0d addr=%0h wdata=%0h alu=%0h rd=%0d stalls=%0d -> wb_we=%0b wb_data=%0h err=%0b",
                 op, addr, wd, alu, rd, stalls, last_we, last_data, last_err);
    endtask

    task automatic idle(input int n);
        ex_valid = 1'b0;
        ex_op    = 2'b00;
        for (int i = 0; i < n; i++) cycle();
    endtask

    int st;
    int wea_hits;

    initial begin
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        ex_op    = 2'b00;
        ex_addr  = '0;
        ex_wdata = '0;
        ex_alu   = '0;
        ex_rd    = '0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'($urandom);

        // Reset state
        #12;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_mem_wea", 32'(mem_wea), 32'd0);
        chk("rst_mem_addra", 32'(mem_addra), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        #9;
        rst_n = 1'b1;

        // PASS alu=0x1234 rd=2
        issue(2'b00, 16'h0, 16'h0, 16'h1234, 3'd2, st);
        chk("pass_valid", 32'(last_valid), 32'd1);
        chk("pass_we", 32'(last_we), 32'd1);
        chk("pass_rd", 32'(last_rd), 32'd2);
        chk("pass_data", 32'(last_data), 32'h1234);

        // STORE then LOAD to address 5
        issue(2'b10, 16'd5, 16'hBEEF, 16'h0, 3'd1, st);
        chk("st5_no_err", 32'(last_err), 32'd0);
        chk("st5_we", 32'(last_we), 32'd0);
        issue(2'b01, 16'd5, 16'h0, 16'h0, 3'd3, st);
        chk("ld5_data", 32'(last_data), 32'hBEEF);
        chk("ld5_stalled", 32'(st > 0), 32'(!FWD));
        idle(12);

        // Six back-to-back stores overrun the 4-deep buffer
        for (int i = 0; i < 6; i++) begin
            issue(2'b10, 16'(20 + i), 16'(16'hA000 + i), 16'h0, 3'd0, st);
            if (i == 5) chk("burst_6th_stalled", 32'(st > 0), 32'd1);
        end
        idle(16);
        for (int i = 0; i < 6; i++) chk("burst_mem", 32'(mem[20 + i]), 32'(16'hA000 + i));

        // Two stores to the same address: youngest wins
        issue(2'b10, 16'd7, 16'h1111, 16'h0, 3'd0, st);
        issue(2'b10, 16'd7, 16'h2222, 16'h0, 3'd0, st);
        issue(2'b01, 16'd7, 16'h0, 16'h0, 3'd4, st);
        chk("ld7_youngest", 32'(last_data), 32'h2222);
        idle(12);
        chk("mem7_final", 32'(mem[7]), 32'h2222);

        // Out-of-range store and load
        issue(2'b10, 16'd64, 16'hDEAD, 16'h0, 3'd0, st);
        chk("st64_err", 32'(last_err), 32'd1);
        chk("st64_we", 32'(last_we), 32'd0);
        wea_hits = 0;
        ex_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (mem_wea) wea_hits++;
        end
        chk("st64_no_write", 32'(wea_hits), 32'd0);
        issue(2'b01, 16'd64, 16'h0, 16'h0, 3'd5, st);
        chk("ld64_err", 32'(last_err), 32'd1);
        chk("ld64_we", 32'(last_we), 32'd1);
        chk("ld64_data", 32'(last_data), 32'd0);
        idle(4);

        // Reset asserted while a queued store is in its WRITE cycle
        for (int i = 0; i < 4; i++) issue(2'b10, 16'(30 + i), 16'(16'h5500 + i), 16'h0, 3'd0, st);
        ex_valid = 1'b0;
        for (int i = 0; i < 10 && !mem_wea; i++) cycle();
        chk("mid_drain_wea_seen", 32'(mem_wea), 32'd1);
        chk("mid_drain_queued", 32'(sbq.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wea", 32'(mem_wea), 32'd0);
        chk("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        sbq.delete();
        gap      = 0;
        prev_wea = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_addra = mem_addra;
        prev_din   = mem_din;
        wea_hits   = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (mem_wea) wea_hits++;
        end
        chk("rst_discards_queue", 32'(wea_hits), 32'd0);
        issue(2'b01, 16'd30, 16'h0, 16'h0, 3'd6, st);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r;
            ex_valid = ($urandom_range(0, 4) != 0);
            ex_op    = 2'($urandom_range(0, 3));
            r        = int'($urandom_range(0, 15));
            if (r == 0)      ex_addr = 16'(64 + $urandom_range(0, 65000));
            else if (r == 1) ex_addr = 16'd63;
            else             ex_addr = 16'($urandom_range(0, 9));
            ex_wdata = 16'($urandom);
            ex_alu   = 16'($urandom);
            ex_rd    = 3'($urandom);
            cycle();
            if (last_acc)
                $display("rand op=%0d addr=%0h -> wb_we=%0b wb_rd=%0d wb_data=%0h err=%0b",
                         ex_op, ex_addr, last_we, last_rd, last_data, last_err);
        end
        idle(20);
        chk("final_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
